// File: rtl/restoring_divider_ctrl_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and default sizes.
package restoring_divider_ctrl_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/restoring_divider_ctrl_sub_stage.sv
// N-bit ripple subtractor (a - b) built from full-subtractor cells, borrow-in 0.
module div_sub_stage #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow_out
);
   logic [N:0] bw;

   assign bw[0] = 1'b0;

   for (genvar i = 0; i < N; i++) begin : g_cell
      assign diff[i]  = a[i] ^ b[i] ^ bw[i];
      assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
   end

   assign borrow_out = bw[N];
endmodule

// File: rtl/restoring_divider_ctrl.sv
// Multi-cycle unsigned restoring divider: one subtractor stage reused for WIDTH
// iterations, start/done handshake, results held until the next accepted start.
module restoring_divider_ctrl
   import restoring_divider_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   p_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic             dbz_q;

   logic [WIDTH:0]   s_w;
   logic [WIDTH:0]   t_w;
   logic             borrow_w;
   logic [WIDTH:0]   p_d;
   logic [WIDTH-1:0] q_d;
   logic             unused_p_msb;

   // P never exceeds D after a restoring step, so its top bit is only
   // needed transiently inside S/T.
   assign unused_p_msb = p_q[WIDTH];

   assign s_w = {p_q[WIDTH-1:0], q_q[WIDTH-1]};

   div_sub_stage #(.N(WIDTH + 1)) u_sub (
      .a         (s_w),
      .b         ({1'b0, d_q}),
      .diff      (t_w),
      .borrow_out(borrow_w)
   );

   always_comb begin
      p_d = borrow_w ? s_w : t_w;
      q_d = {q_q[WIDTH-2:0], ~borrow_w};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     quot_q  <= '1;
                     rem_q   <= dividend;
                     dbz_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     d_q     <= divisor;
                     q_q     <= dividend;
                     p_q     <= '0;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               p_q   <= p_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  quot_q  <= q_d;
                  rem_q   <= p_d[WIDTH-1:0];
                  dbz_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Self-checking bench for restoring_divider_ctrl against a plain-arithmetic model.
module tb_restoring_divider_ctrl;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int vectors = 0;
   int miscompares = 0;

   restoring_divider_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic z);
      if (b == 0) begin
         q = '1; r = a; z = 1'b1;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   // Pulse start for one cycle, then wait for done (bounded). lat = cycles from
   // the start cycle to the done cycle, or -1 on timeout.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt, output int dcnt);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bcnt = int'(busy); dcnt = int'(done);
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++; bcnt += int'(busy); dcnt += int'(done);
      end
      if (!done) lat = -1;
      @(negedge clk);
      dcnt += int'(done);
   endtask

   task automatic check_op(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eq, er;
      logic ez;
      int lat, bcnt, dcnt, elat, ebusy;
      model(a, b, eq, er, ez);
      elat  = (b == 0) ? 1 : W + 1;
      ebusy = (b == 0) ? 0 : W;
      run_op(a, b, lat, bcnt, dcnt);
      vectors++;
      if (lat !== elat) begin
         miscompares++;
         $display("FAIL latency %0d/%0d: got %0d expected %0d", a, b, lat, elat);
      end
      vectors++;
      if (bcnt !== ebusy) begin
         miscompares++;
         $display("FAIL busy_cycles %0d/%0d: got %0d expected %0d", a, b, bcnt, ebusy);
      end
      vectors++;
      if (dcnt !== 1) begin
         miscompares++;
         $display("FAIL done_pulses %0d/%0d: got %0d expected 1", a, b, dcnt);
      end
      vectors++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
         miscompares++;
         $display("FAIL result %h/%h: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                  a, b, quotient, remainder, div_by_zero, eq, er, ez);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b done=%b z=%b q=%h r=%h expected all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [6] = '{32'd100, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'd1234, 32'd9};
      logic [W-1:0] tb [6] = '{32'd7, 32'h8000_0000, 32'd10, 32'd1, 32'd0, 32'd3};
      for (int i = 0; i < 6; i++) check_op(ta[i], tb[i]);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = (i % 8 == 0) ? 32'd0 : 32'($urandom_range(1, 255));
            1: b = $urandom;
            2: b = $urandom >> $urandom_range(0, 31);
            default: b = 32'h8000_0000 | $urandom;
         endcase
         check_op(a, b);
      end
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] oq, or_;
      int lat, dcnt;
      oq = quotient; or_ = remainder;
      @(negedge clk);
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0; lat = 1; dcnt = 0;
      while (!done && lat < 100) begin
         if (lat == 10) begin
            start = 1'b1; dividend = 32'd50; divisor = 32'd5;
         end else if (lat == 11) begin
            start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd3;
         end
         if (lat == 12) begin
            vectors++;
            if (quotient !== oq || remainder !== or_ || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL hold_during_run: got q=%h r=%h busy=%b expected q=%h r=%h busy=1",
                        quotient, remainder, busy, oq, or_);
            end
         end
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
      vectors++;
      if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
         miscompares++;
         $display("FAIL start_ignored: got lat=%0d q=%0d r=%0d expected lat=33 q=14 r=2",
                  lat, quotient, remainder);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         dcnt += int'(done) + int'(busy);
      end
      vectors++;
      if (dcnt !== 0 || quotient !== 32'd14 || remainder !== 32'd2) begin
         miscompares++;
         $display("FAIL single_done: got extra activity=%0d q=%0d r=%0d expected 0 14 2",
                  dcnt, quotient, remainder);
      end
   endtask

   task automatic test_reset_midrun();
      int act;
      @(negedge clk);
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         miscompares++;
         $display("FAIL reset_midrun: got busy=%b done=%b z=%b q=%h r=%h expected all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      act = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         act += int'(done) + int'(busy);
      end
      vectors++;
      if (act !== 0) begin
         miscompares++;
         $display("FAIL no_done_after_reset: got activity=%0d expected 0", act);
      end
      check_op(32'd20, 32'd6);
   endtask

   task automatic test_back_to_back();
      int lat, gap;
      logic [W-1:0] eq, er;
      logic ez;
      // start held high: the DONE cycle must swallow it, then IDLE accepts.
      @(negedge clk);
      start = 1'b1; dividend = 32'd77; divisor = 32'd0;
      @(negedge clk);
      dividend = 32'd1000; divisor = 32'd33;
      vectors++;
      if (done !== 1'b1 || div_by_zero !== 1'b1 || remainder !== 32'd77) begin
         miscompares++;
         $display("FAIL b2b_first: got done=%b z=%b r=%0d expected 1 1 77",
                  done, div_by_zero, remainder);
      end
      @(negedge clk);
      gap = int'(busy) + int'(done);
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (gap !== 0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_idle_gap: got gap_activity=%0d busy=%b expected 0 1", gap, busy);
      end
      lat = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
      model(32'd1000, 32'd33, eq, er, ez);
      vectors++;
      if (lat !== 33 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
         miscompares++;
         $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d z=%b expected 33 %0d %0d %b",
                  lat, quotient, remainder, div_by_zero, eq, er, ez);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_reset_midrun();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
